// File: rtl/aurora_pkg.sv
// Shared types and constants for the Aurora receive path.
package aurora_pkg;

  // Native flow control request state
  typedef enum logic [1:0] {
    XON_IDLE  = 2'd0,
    XOFF_REQ  = 2'd1,
    XOFF_HOLD = 2'd2,
    XON_REQ   = 2'd3
  } nfc_state_t;

  // Pause code that resumes the link partner
  localparam logic [15:0] NFC_XON = 16'h0000;

endpackage

// File: rtl/aurora_fifo_ram.sv
// Simple dual-port storage: synchronous write, combinational read.
module aurora_fifo_ram #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Combinational read gives first-word-fall-through behaviour
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/aurora_rx_fifo_nfc.sv
// Aurora RX buffer: FWFT FIFO, watermarks, overflow accounting and NFC XOFF/XON.
module aurora_rx_fifo_nfc
  import aurora_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned KEEP_W     = DATA_W / 8,
  parameter int unsigned FIFO_DEPTH = 32,
  parameter int unsigned FIFO_LWM   = 16,
  parameter int unsigned FIFO_HWM   = 24,
  parameter logic [15:0] NFC_XOFF   = 16'h00FF,
  parameter int unsigned NFC_RETX   = 200,
  parameter int unsigned OVF_CNT_W  = 16
) (
  input  logic                            rst,
  input  logic                            clk,
  output logic                            fifo_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                            fifo_below_lwm,
  output logic                            fifo_above_hwm,
  output logic                            ovf_flag,
  output logic [OVF_CNT_W-1:0]            ovf_count,
  input  logic                            ovf_clr,
  input  logic [DATA_W-1:0]               i_tdata,
  input  logic [KEEP_W-1:0]               i_tkeep,
  input  logic                            i_tvalid,
  input  logic                            i_tlast,
  output logic [DATA_W-1:0]               o_tdata,
  output logic [KEEP_W-1:0]               o_tkeep,
  output logic                            o_tvalid,
  output logic                            o_tlast,
  input  logic                            o_tready,
  output logic                            nfc_tvalid,
  output logic [15:0]                     nfc_tdata,
  input  logic                            nfc_tready
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned MW = KEEP_W + DATA_W + 1;
  localparam int unsigned TW = $clog2(NFC_RETX + 1);

  logic                 ready_q;
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]        level_q, level_d;
  logic                 below_q, above_q;
  logic                 ovf_flag_q, ovf_flag_d;
  logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic                 full, wr_en, rd_en, drop;
  logic [MW-1:0]        rd_word;
  nfc_state_t           state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 nfc_tvalid_q, nfc_tvalid_d;
  logic [15:0]          nfc_tdata_q, nfc_tdata_d;

  assign full     = (level_q == LW'(FIFO_DEPTH));
  assign wr_en    = i_tvalid & ready_q & ~full;
  assign drop     = i_tvalid & ready_q & full;
  assign o_tvalid = ready_q & (level_q != '0);
  assign rd_en    = o_tvalid & o_tready;

  aurora_fifo_ram #(
    .WIDTH (MW),
    .DEPTH (FIFO_DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i ({i_tkeep, i_tlast, i_tdata}),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_word)
  );

  assign {o_tkeep, o_tlast, o_tdata} = rd_word;

  // Level counter: unchanged when a write and a read coincide
  always_comb begin
    level_d = level_q;
    if (wr_en && !rd_en)      level_d = level_q + LW'(1);
    else if (!wr_en && rd_en) level_d = level_q - LW'(1);
  end

  // Overflow accounting; a drop in the same cycle as a clear takes priority
  always_comb begin
    ovf_flag_d = ovf_flag_q;
    ovf_cnt_d  = ovf_cnt_q;
    if (drop) begin
      ovf_flag_d = 1'b1;
      if (ovf_clr)                ovf_cnt_d = OVF_CNT_W'(1);
      else if (ovf_cnt_q != '1)   ovf_cnt_d = ovf_cnt_q + OVF_CNT_W'(1);
    end else if (ovf_clr) begin
      ovf_flag_d = 1'b0;
      ovf_cnt_d  = '0;
    end
  end

  // FIFO pointers, level, watermarks and overflow registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      below_q    <= 1'b1;
      above_q    <= 1'b0;
      ovf_flag_q <= 1'b0;
      ovf_cnt_q  <= '0;
    end else begin
      ready_q    <= 1'b1;
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q    <= level_d;
      below_q    <= (level_d < LW'(FIFO_LWM));
      above_q    <= (level_d > LW'(FIFO_HWM));
      ovf_flag_q <= ovf_flag_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  // NFC state register, refresh timer and registered request outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= XON_IDLE;
      timer_q      <= '0;
      nfc_tvalid_q <= 1'b0;
      nfc_tdata_q  <= NFC_XON;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      nfc_tvalid_q <= nfc_tvalid_d;
      nfc_tdata_q  <= nfc_tdata_d;
    end
  end

  // NFC next state: requests complete before watermarks are looked at again
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      XON_IDLE: begin
        if (above_q) state_d = XOFF_REQ;
      end
      XOFF_REQ: begin
        if (nfc_tready) begin
          state_d = XOFF_HOLD;
          timer_d = TW'(NFC_RETX - 1);
        end
      end
      XOFF_HOLD: begin
        if (below_q)              state_d = XON_REQ;
        else if (timer_q == '0)   state_d = XOFF_REQ;
        else                      timer_d = timer_q - TW'(1);
      end
      XON_REQ: begin
        if (nfc_tready) state_d = XON_IDLE;
      end
      default: state_d = XON_IDLE;
    endcase
  end

  // NFC request decode from the upcoming state, registered above
  always_comb begin
    nfc_tvalid_d = (state_d == XOFF_REQ) || (state_d == XON_REQ);
    nfc_tdata_d  = (state_d == XOFF_REQ) ? NFC_XOFF : NFC_XON;
  end

  assign fifo_ready     = ready_q;
  assign fifo_level     = level_q;
  assign fifo_below_lwm = below_q;
  assign fifo_above_hwm = above_q;
  assign ovf_flag       = ovf_flag_q;
  assign ovf_count      = ovf_cnt_q;
  assign nfc_tvalid     = nfc_tvalid_q;
  assign nfc_tdata      = nfc_tdata_q;

endmodule

// File: tb/tb_aurora_rx_fifo_nfc.sv
// Self-checking bench for aurora_rx_fifo_nfc with a queue-based reference model.
module tb_aurora_rx_fifo_nfc;

  localparam int DATA_W = 8;
  localparam int KEEP_W = 1;
  localparam int DEPTH  = 32;
  localparam int LWM    = 16;
  localparam int HWM    = 24;
  localparam int RETX   = 200;
  localparam int OVF_W  = 4;
  localparam int LW     = $clog2(DEPTH + 1);
  localparam int OVF_MAX = (1 << OVF_W) - 1;

  typedef struct packed {
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic              rst, clk;
  logic              fifo_ready, fifo_below_lwm, fifo_above_hwm, ovf_flag, ovf_clr;
  logic [LW-1:0]     fifo_level;
  logic [OVF_W-1:0]  ovf_count;
  logic [DATA_W-1:0] i_tdata, o_tdata;
  logic [KEEP_W-1:0] i_tkeep, o_tkeep;
  logic              i_tvalid, i_tlast, o_tvalid, o_tlast, o_tready;
  logic              nfc_tvalid, nfc_tready;
  logic [15:0]       nfc_tdata;

  aurora_rx_fifo_nfc #(
    .DATA_W(DATA_W), .KEEP_W(KEEP_W), .FIFO_DEPTH(DEPTH), .FIFO_LWM(LWM),
    .FIFO_HWM(HWM), .NFC_XOFF(16'h00FF), .NFC_RETX(RETX), .OVF_CNT_W(OVF_W)
  ) dut (
    .rst(rst), .clk(clk), .fifo_ready(fifo_ready), .fifo_level(fifo_level),
    .fifo_below_lwm(fifo_below_lwm), .fifo_above_hwm(fifo_above_hwm),
    .ovf_flag(ovf_flag), .ovf_count(ovf_count), .ovf_clr(ovf_clr),
    .i_tdata(i_tdata), .i_tkeep(i_tkeep), .i_tvalid(i_tvalid), .i_tlast(i_tlast),
    .o_tdata(o_tdata), .o_tkeep(o_tkeep), .o_tvalid(o_tvalid), .o_tlast(o_tlast),
    .o_tready(o_tready), .nfc_tvalid(nfc_tvalid), .nfc_tdata(nfc_tdata),
    .nfc_tready(nfc_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  beat_t mq[$];
  bit    m_ready;
  bit    m_flag;
  int    m_cnt;
  int    pass_cnt;
  int    total_cnt;

  // One clock: predict from pre-edge inputs, advance, return at the falling edge
  task automatic tick();
    bit full, wr, rd, drop;
    beat_t b;
    full = (mq.size() == DEPTH);
    wr   = i_tvalid && m_ready && !full;
    drop = i_tvalid && m_ready && full;
    rd   = m_ready && (mq.size() != 0) && o_tready;
    b.keep = i_tkeep; b.last = i_tlast; b.data = i_tdata;
    @(posedge clk);
    if (rst) begin
      mq.delete(); m_ready = 0; m_flag = 0; m_cnt = 0;
    end else begin
      if (rd) void'(mq.pop_front());
      if (wr) mq.push_back(b);
      if (drop) begin
        m_flag = 1;
        m_cnt  = ovf_clr ? 1 : ((m_cnt < OVF_MAX) ? m_cnt + 1 : m_cnt);
      end else if (ovf_clr) begin
        m_flag = 0; m_cnt = 0;
      end
      m_ready = 1;
    end
    @(negedge clk);
  endtask

  task automatic push(input bit v, input bit rdy);
    i_tvalid = v;
    i_tdata  = DATA_W'($urandom);
    i_tkeep  = KEEP_W'($urandom);
    i_tlast  = 1'($urandom);
    o_tready = rdy;
  endtask

  task automatic test_reset();
    rst = 1; ovf_clr = 0; i_tvalid = 0; i_tdata = '0; i_tkeep = '0; i_tlast = 0;
    o_tready = 0; nfc_tready = 0; m_ready = 0; m_flag = 0; m_cnt = 0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({fifo_ready, fifo_level, fifo_below_lwm, fifo_above_hwm, ovf_flag, ovf_count, o_tvalid}
        !== {1'b0, LW'(0), 1'b1, 1'b0, 1'b0, OVF_W'(0), 1'b0})
      $display("FAIL reset_status: ready=%b lvl=%0d blw=%b ahw=%b of=%b oc=%0d ov=%b exp 0 0 1 0 0 0 0",
               fifo_ready, fifo_level, fifo_below_lwm, fifo_above_hwm, ovf_flag, ovf_count, o_tvalid);
    else pass_cnt++;
    total_cnt++;
    if ({nfc_tvalid, nfc_tdata} !== 17'h0)
      $display("FAIL reset_nfc: valid=%b data=%h exp 0 0000", nfc_tvalid, nfc_tdata);
    else pass_cnt++;
    // Beat presented at the edge where ready first rises must be ignored
    rst = 0; i_tvalid = 1; i_tdata = 8'hAA;
    tick();
    total_cnt++;
    if ({fifo_ready, fifo_level, ovf_flag, o_tvalid} !== {1'b1, LW'(0), 1'b0, 1'b0})
      $display("FAIL reset_release: ready=%b lvl=%0d of=%b ov=%b exp 1 0 0 0",
               fifo_ready, fifo_level, ovf_flag, o_tvalid);
    else pass_cnt++;
    i_tvalid = 0;
  endtask

  task automatic test_basic();
    for (int k = 1; k <= 5; k++) begin
      i_tvalid = 1; i_tdata = DATA_W'(k); i_tkeep = '1; i_tlast = (k == 5); o_tready = 1;
      tick();
      total_cnt++;
      if ({o_tvalid, o_tdata, o_tlast, fifo_level} !== {1'b1, DATA_W'(k), (k == 5), LW'(1)})
        $display("FAIL basic_beat%0d: ov=%b d=%0d last=%b lvl=%0d exp 1 %0d %b 1",
                 k, o_tvalid, o_tdata, o_tlast, fifo_level, k, (k == 5));
      else pass_cnt++;
    end
    i_tvalid = 0;
    tick();
    total_cnt++;
    if ({o_tvalid, fifo_level} !== {1'b0, LW'(0)})
      $display("FAIL basic_empty: ov=%b lvl=%0d exp 0 0", o_tvalid, fifo_level);
    else pass_cnt++;
  endtask

  task automatic test_random_stream();
    nfc_tready = 1;
    for (int c = 0; c < 600; c++) begin
      push($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45);
      ovf_clr = ($urandom_range(0, 31) == 0);
      tick();
      total_cnt++;
      if (fifo_level !== LW'(mq.size()))
        $display("FAIL rand_level c%0d: got %0d exp %0d", c, fifo_level, mq.size());
      else pass_cnt++;
      total_cnt++;
      if ({o_tvalid, fifo_below_lwm, fifo_above_hwm}
          !== {mq.size() != 0, mq.size() < LWM, mq.size() > HWM})
        $display("FAIL rand_flags c%0d: ov/blw/ahw got %b%b%b exp %b%b%b", c, o_tvalid,
                 fifo_below_lwm, fifo_above_hwm, mq.size() != 0, mq.size() < LWM, mq.size() > HWM);
      else pass_cnt++;
      total_cnt++;
      if ({ovf_flag, ovf_count} !== {m_flag, OVF_W'(m_cnt)})
        $display("FAIL rand_ovf c%0d: flag=%b cnt=%0d exp %b %0d", c, ovf_flag, ovf_count, m_flag, m_cnt);
      else pass_cnt++;
      if (mq.size() != 0) begin
        total_cnt++;
        if ({o_tkeep, o_tlast, o_tdata} !== mq[0])
          $display("FAIL rand_head c%0d: got %h exp %h", c, {o_tkeep, o_tlast, o_tdata}, mq[0]);
        else pass_cnt++;
      end
    end
    ovf_clr = 0;
  endtask

  task automatic settle();
    i_tvalid = 0; o_tready = 1; nfc_tready = 1; ovf_clr = 1;
    tick();
    ovf_clr = 0;
    repeat (50) tick();
    o_tready = 0;
    total_cnt++;
    if ({fifo_level, ovf_count, nfc_tvalid} !== {LW'(0), OVF_W'(0), 1'b0})
      $display("FAIL settle: lvl=%0d oc=%0d nv=%b exp 0 0 0", fifo_level, ovf_count, nfc_tvalid);
    else pass_cnt++;
  endtask

  task automatic test_nfc_xoff();
    int n;
    nfc_tready = 1;
    for (int k = 0; k < 25; k++) begin
      push(1, 0);
      tick();
    end
    i_tvalid = 0;
    total_cnt++;
    if ({fifo_level, fifo_above_hwm, nfc_tvalid} !== {LW'(25), 1'b1, 1'b0})
      $display("FAIL xoff_cross: lvl=%0d ahw=%b nv=%b exp 25 1 0", fifo_level, fifo_above_hwm, nfc_tvalid);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({nfc_tvalid, nfc_tdata} !== {1'b1, 16'h00FF})
      $display("FAIL xoff_req: nv=%b nd=%h exp 1 00ff", nfc_tvalid, nfc_tdata);
    else pass_cnt++;
    // Refresh: next XOFF appears RETX cycles after acceptance
    for (int r = 0; r < 2; r++) begin
      tick();
      n = 0;
      while (!nfc_tvalid && n < 300) begin
        tick();
        n++;
      end
      total_cnt++;
      if (n !== RETX || nfc_tdata !== 16'h00FF)
        $display("FAIL xoff_refresh%0d: interval=%0d nd=%h exp %0d 00ff", r, n, nfc_tdata, RETX);
      else pass_cnt++;
    end
  endtask

  task automatic test_nfc_xon();
    int xon, xoff;
    xon = 0; xoff = 0;
    i_tvalid = 0; o_tready = 1; nfc_tready = 1;
    for (int c = 0; c < 260; c++) begin
      if (mq.size() == 15) o_tready = 0;
      tick();
      if (nfc_tvalid && nfc_tdata == 16'h0000) xon++;
      if (nfc_tvalid && nfc_tdata == 16'h00FF) xoff++;
    end
    total_cnt++;
    if ({fifo_level, fifo_below_lwm} !== {LW'(15), 1'b1})
      $display("FAIL xon_level: lvl=%0d blw=%b exp 15 1", fifo_level, fifo_below_lwm);
    else pass_cnt++;
    total_cnt++;
    if (xon !== 1 || xoff !== 0 || nfc_tvalid !== 1'b0)
      $display("FAIL xon_once: xon=%0d xoff=%0d nv=%b exp 1 0 0", xon, xoff, nfc_tvalid);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 17; k++) begin
      push(1, 0);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      push(1, 0);
      tick();
    end
    total_cnt++;
    if ({fifo_level, ovf_flag, ovf_count} !== {LW'(32), 1'b1, OVF_W'(3)})
      $display("FAIL ovf_three: lvl=%0d of=%b oc=%0d exp 32 1 3", fifo_level, ovf_flag, ovf_count);
    else pass_cnt++;
    // A full FIFO still drops even while a beat is being read out
    push(1, 1);
    tick();
    total_cnt++;
    if ({fifo_level, ovf_count} !== {LW'(31), OVF_W'(4)} || {o_tkeep, o_tlast, o_tdata} !== mq[0])
      $display("FAIL ovf_with_read: lvl=%0d oc=%0d head=%h exp 31 4 %h",
               fifo_level, ovf_count, {o_tkeep, o_tlast, o_tdata}, mq[0]);
    else pass_cnt++;
    push(1, 0);
    tick();
    push(1, 0); ovf_clr = 1;
    tick();
    total_cnt++;
    if ({fifo_level, ovf_flag, ovf_count} !== {LW'(32), 1'b1, OVF_W'(1)})
      $display("FAIL ovf_clr_vs_drop: lvl=%0d of=%b oc=%0d exp 32 1 1", fifo_level, ovf_flag, ovf_count);
    else pass_cnt++;
    i_tvalid = 0;
    tick();
    ovf_clr = 0;
    total_cnt++;
    if ({ovf_flag, ovf_count} !== {1'b0, OVF_W'(0)})
      $display("FAIL ovf_clear: of=%b oc=%0d exp 0 0", ovf_flag, ovf_count);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 20; k++) begin
      push(1, 0);
      tick();
    end
    i_tvalid = 0;
    total_cnt++;
    if ({fifo_level, ovf_flag, ovf_count} !== {LW'(32), 1'b1, OVF_W'(OVF_MAX)} || m_cnt != OVF_MAX)
      $display("FAIL ovf_saturate: lvl=%0d of=%b oc=%0d exp 32 1 %0d", fifo_level, ovf_flag, ovf_count, OVF_MAX);
    else pass_cnt++;
  endtask

  task automatic test_nfc_stall_reset();
    int n;
    nfc_tready = 0; i_tvalid = 0; o_tready = 0;
    n = 0;
    while (!nfc_tvalid && n < 300) begin
      tick();
      n++;
    end
    total_cnt++;
    if (nfc_tvalid !== 1'b1)
      $display("FAIL stall_wait: no XOFF request within %0d cycles", n);
    else pass_cnt++;
    for (int c = 0; c < 10; c++) begin
      tick();
      total_cnt++;
      if ({nfc_tvalid, nfc_tdata} !== {1'b1, 16'h00FF})
        $display("FAIL stall_hold c%0d: nv=%b nd=%h exp 1 00ff", c, nfc_tvalid, nfc_tdata);
      else pass_cnt++;
    end
    // Asynchronous reset between clock edges
    #2 rst = 1;
    mq.delete(); m_ready = 0; m_flag = 0; m_cnt = 0;
    #1;
    total_cnt++;
    if ({nfc_tvalid, fifo_level, fifo_ready, o_tvalid, ovf_flag} !== {1'b0, LW'(0), 1'b0, 1'b0, 1'b0})
      $display("FAIL async_reset: nv=%b lvl=%0d ready=%b ov=%b of=%b exp 0 0 0 0 0",
               nfc_tvalid, fifo_level, fifo_ready, o_tvalid, ovf_flag);
    else pass_cnt++;
    @(negedge clk);
    rst = 0; nfc_tready = 1;
    push(1, 0);
    tick();
    total_cnt++;
    if ({fifo_ready, fifo_level} !== {1'b1, LW'(0)})
      $display("FAIL post_reset_ignore: ready=%b lvl=%0d exp 1 0", fifo_ready, fifo_level);
    else pass_cnt++;
    push(1, 0);
    tick();
    i_tvalid = 0;
    total_cnt++;
    if ({o_tvalid, fifo_level} !== {1'b1, LW'(1)} || {o_tkeep, o_tlast, o_tdata} !== mq[0])
      $display("FAIL post_reset_write: ov=%b lvl=%0d head=%h exp 1 1 %h",
               o_tvalid, fifo_level, {o_tkeep, o_tlast, o_tdata}, mq[0]);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset();
    test_basic();
    test_random_stream();
    settle();
    test_nfc_xoff();
    test_nfc_xon();
    test_overflow();
    test_saturation();
    test_nfc_stall_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
